// File: rtl/mux_2_1_new_pkg.sv
// Shared constants for the registered 2:1 multiplexer.
// Select encodings and default parameter values used by mux_2_1_new and its bench.

package mux_2_1_new_pkg;

    localparam logic SEL_IN0 = 1'b0;
    localparam logic SEL_IN1 = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 1;
    localparam int unsigned MAX_WIDTH     = 64;

    // Sliced down to WIDTH by the top-level parameter default.
    localparam logic [MAX_WIDTH-1:0] DEFAULT_RST_VAL = '0;

endpackage

// File: rtl/mux2_1_cell.sv
// Purely combinational WIDTH-bit 2:1 select; all bits come from the same source.

module mux2_1_cell
    import mux_2_1_new_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             S,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in0;
        if (S == SEL_IN1) begin
            out = in1;
        end
    end

endmodule

// File: rtl/mux_2_1_new.sv
// Registered 2:1 multiplexer with valid qualifier and select-change debug flag.
// Optional even-parity output enabled by defining MUX2_1_NEW_PARITY_EN.

module mux_2_1_new
    import mux_2_1_new_pkg::*;
#(
    parameter int unsigned       WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  RST_VAL = DEFAULT_RST_VAL[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             S,
    input  logic             vld_in,
    output logic [WIDTH-1:0] res,
    output logic             vld_out,
    output logic             sel_chg
`ifdef MUX2_1_NEW_PARITY_EN
    ,
    output logic             par
`endif
);

    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] res_d;
    logic             last_sel_q, last_sel_d;
    logic             seen_q, seen_d;
    logic             sel_chg_d;

    mux2_1_cell #(
        .WIDTH (WIDTH)
    ) u_cell (
        .in0 (in0),
        .in1 (in1),
        .S   (S),
        .out (sel_word)
    );

    always_comb begin
        res_d      = res;
        last_sel_d = last_sel_q;
        seen_d     = seen_q;
        sel_chg_d  = 1'b0;
        if (vld_in) begin
            res_d      = sel_word;
            last_sel_d = S;
            seen_d     = 1'b1;
            // The first word after reset has no predecessor to compare against.
            sel_chg_d  = seen_q & (S != last_sel_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res        <= RST_VAL;
            vld_out    <= 1'b0;
            sel_chg    <= 1'b0;
            last_sel_q <= SEL_IN0;
            seen_q     <= 1'b0;
        end else begin
            res        <= res_d;
            vld_out    <= vld_in;
            sel_chg    <= sel_chg_d;
            last_sel_q <= last_sel_d;
            seen_q     <= seen_d;
        end
    end

`ifdef MUX2_1_NEW_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par <= ^RST_VAL;
        end else begin
            par <= ^res_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux_2_1_new.sv
// Self-checking bench for mux_2_1_new: directed cases plus randomized traffic
// against a history-based reference model.

module tb_mux_2_1_new;

    localparam int unsigned W = 8;
    localparam logic [W-1:0] RST_V = '0;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in0, in1;
    logic         S, vld_in;
    logic [W-1:0] res;
    logic         vld_out, sel_chg;
`ifdef MUX2_1_NEW_PARITY_EN
    logic         par;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: the selects of all words accepted since the last reset.
    bit           acc_sel[$];
    logic [W-1:0] m_res;
    logic         m_vld, m_chg;

    always #5 clk = ~clk;

    mux_2_1_new #(
        .WIDTH   (W),
        .RST_VAL (RST_V)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in0     (in0),
        .in1     (in1),
        .S       (S),
        .vld_in  (vld_in),
        .res     (res),
        .vld_out (vld_out),
        .sel_chg (sel_chg)
`ifdef MUX2_1_NEW_PARITY_EN
        ,
        .par     (par)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic v);
        rst    = r;
        in0    = a;
        in1    = b;
        S      = s;
        vld_in = v;
        @(posedge clk);
        if (r) begin
            acc_sel.delete();
            m_res = RST_V;
            m_vld = 1'b0;
            m_chg = 1'b0;
        end else begin
            m_vld = v;
            m_chg = 1'b0;
            if (v) begin
                if (acc_sel.size() > 0) m_chg = (acc_sel[$] != s);
                acc_sel.push_back(s);
                m_res = s ? b : a;
            end
        end
        #1;
        check_eq("res", 64'(res), 64'(m_res));
        check_eq("vld_out", 64'(vld_out), 64'(m_vld));
        check_eq("sel_chg", 64'(sel_chg), 64'(m_chg));
`ifdef MUX2_1_NEW_PARITY_EN
        // Even parity: par plus the ones in res totals an even count.
        check_eq("par", 64'(par), 64'($countones(m_res) % 2));
`endif
    endtask

    initial begin
        rst = 1'b1; in0 = '0; in1 = '0; S = 1'b0; vld_in = 1'b0;
        m_res = RST_V; m_vld = 1'b0; m_chg = 1'b0;

        // Reset wins over a valid word presented in the same cycle.
        step(1'b1, 8'h01, 8'h01, 1'b1, 1'b1);
        step(1'b1, 8'h01, 8'h01, 1'b1, 1'b1);
        check_eq("reset_res_const", 64'(res), 64'h0);

        // Select in0, then in1, then equal inputs.
        step(1'b0, 8'h00, 8'h01, 1'b0, 1'b1);
        step(1'b0, 8'h01, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h01, 8'h00, 1'b1, 1'b1);
        check_eq("sel_chg_0to1", 64'(sel_chg), 64'h1);
        step(1'b0, 8'h00, 8'h01, 1'b1, 1'b1);
        check_eq("sel_chg_steady", 64'(sel_chg), 64'h0);
        step(1'b0, 8'h01, 8'h01, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);

        // Hold: inputs toggle with vld_in low.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'(i * 37), ~8'(i * 37), 1'(i), 1'b0);
        end

        // Parity patterns.
        step(1'b0, 8'h07, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 8'h03, 1'b1, 1'b1);

        // Mid-stream reset: the next accepted word is a first word.
        step(1'b0, 8'h55, 8'hAA, 1'b0, 1'b1);
        step(1'b1, 8'h11, 8'h22, 1'b1, 1'b1);
        step(1'b0, 8'h33, 8'h44, 1'b1, 1'b1);
        check_eq("first_after_rst", 64'(sel_chg), 64'h0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), 8'($urandom), 8'($urandom),
                 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
